affine_core_p: RTL and testbench
================================

# affine_core_p

Parametrised successor to the fixed-width affine core: a single-issue, one-instruction-per-cycle sequencer with a writable program store, an NREG-entry register file and a valid/ready input port. It adds several things the fixed core lacks: run/halt control with restart, conditional branching, stall on external input, and registered output strobes. It sits between the external data interface and the host that loads programs.

## Interface

- N, 8, data/register width (≥2)
- DEPTH, 16, program words (power of two, ≥4); A = $clog2(DEPTH)
- NREG, 8, register count (power of two); R = $clog2(NREG)
- W_INST, derived = 4 + 2R + N; fields LSB-first: op[4], rd[R], rs[R], imm[N]

Ports:

- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- prog_we_i  in  1  program-store write strobe
- prog_addr_i  in  A  write address
- prog_data_i  in  W_INST  write data
- start_i  in  1  begin execution at pc 0
- ext_data_i  in  N  input data
- ext_valid_i  in  1  input data valid
- ext_ready_o  out  1  core accepting input this cycle
- ext_data_o  out  N  last OUT value (held)
- ext_strobe_o  out  1  one-cycle pulse when ext_data_o updates
- busy_o  out  1  state == RUN
- halted_o  out  1  state == HALTED

## Operation

- States: IDLE, RUN, HALTED.
  - IDLE→RUN on start_i, with pc←0.
  - RUN→HALTED on HALT.
  - HALTED→RUN on start_i, with pc←0; registers are retained.
- Program store is DEPTH×W_INST with combinational read at pc.
  - Writes take effect only in IDLE/HALTED; in RUN, prog_we_i is ignored.
- Opcodes (anything else executes as NOP):
  - 0 NOP
  - 1 LDI: rd←imm
  - 2 ADD: rd←rd+rs
  - 3 SUB: rd←rd−rs
  - 4 MUL: rd←low N bits of rd×rs
  - 5 MAC: rd←rd+low N bits of rs×imm
  - 6 IN: rd←ext_data_i
  - 7 OUT: ext_data_o←rs, strobe
  - 8 BNZ: if rs≠0 then pc←imm[A-1:0]
  - 9 DJNZ: rd←rd−1; if the result ≠0 then pc←imm[A-1:0]
  - 15 HALT
- Arithmetic is unsigned modulo 2^N. DJNZ with rd=0 wraps to 2^N−1 and branches.
- Default next pc is pc+1 modulo DEPTH; pc at DEPTH−1 wraps to 0.
- IN:
  - ext_ready_o=1 while RUN and op==IN.
  - pc and registers stall until ext_valid_i=1.
  - The transfer completes in the cycle where valid&&ready.
- Register r0 is an ordinary, writable register.

## Timing

- Reset values: state IDLE, pc 0, all registers 0, ext_data_o 0, ext_strobe_o 0, ext_ready_o 0, busy_o 0, halted_o 0. Program store is not reset.
- start_i in cycle t puts busy_o high at t+1. The instruction at address 0 commits at edge t+2.
- Each non-stalled instruction commits in one cycle. A register written at edge k is visible to the instruction at edge k+1; there is no hazard.
- OUT committing at edge k gives ext_data_o updated and ext_strobe_o=1 for the cycle after k.
- HALT committing at edge k gives halted_o=1 and busy_o=0 after k. The HALT instruction causes no register write.
- start_i in RUN is ignored.
- rst_i dominates every other input, including mid-stall and mid-program write.
- prog_we_i together with start_i in IDLE: the write completes and the new word is executed if addr==0.

## Structure

- Package affine_p_pkg holds:
  - typedef enum tOpP (4-bit opcodes above)
  - typedef enum tStateP
  - field-offset functions of N/R
- Sub-module affine_rf_p (NREG×N, two async reads rd/rs, one sync write, synchronous-reset clear).
- The program store and the ALU live in affine_core_p.

## Test plan

- Reset then start:
  - Program LDI r1,5; LDI r2,7; ADD r1,r2; OUT r1; HALT.
  - Required: ext_data_o=12 with one strobe, then halted_o=1.
- Wrap:
  - Program LDI r1,250; LDI r2,10; ADD r1,r2; OUT r1.
  - Required: output 4. Also check SUB of 3−5 gives 254.
- Loop:
  - Program LDI r3,4; LDI r1,0; MAC r1,r2(=3 via LDI),imm 2; DJNZ r3→MAC; OUT r1; HALT.
  - Required: output 24, exactly 4 MAC commits.
- IN stall:
  - Hold ext_valid_i low 5 cycles during IN r1.
  - Required: ext_ready_o high throughout, pc frozen. Then valid with 0x3C makes OUT show 0x3C.
- Control:
  - prog_we_i in RUN leaves the store unchanged.
  - start_i in HALTED reruns from pc 0 with registers retained.
  - PC wraps from DEPTH−1 to 0 on a program with no HALT.
- rst_i asserted mid-stall:
  - Required: next cycle state IDLE, all outputs 0, registers 0.

Source files
------------

// File: rtl/affine_p_pkg.sv
// Shared types and instruction-field layout for the parametrised affine sequencer.
package affine_p_pkg;

  typedef enum logic [3:0] {
    OpNop  = 4'd0,
    OpLdi  = 4'd1,
    OpAdd  = 4'd2,
    OpSub  = 4'd3,
    OpMul  = 4'd4,
    OpMac  = 4'd5,
    OpIn   = 4'd6,
    OpOut  = 4'd7,
    OpBnz  = 4'd8,
    OpDjnz = 4'd9,
    OpHalt = 4'd15
  } tOpP;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalted
  } tStateP;

  localparam int unsigned OpW = 4;

  // Fields are packed LSB-first: op, rd, rs, imm.
  function automatic int unsigned rd_lsb();
    return OpW;
  endfunction

  function automatic int unsigned rs_lsb(input int unsigned r);
    return OpW + r;
  endfunction

  function automatic int unsigned imm_lsb(input int unsigned r);
    return OpW + 2 * r;
  endfunction

  function automatic int unsigned inst_w(input int unsigned n, input int unsigned r);
    return OpW + 2 * r + n;
  endfunction

endpackage

// File: rtl/affine_rf_p.sv
// NREG x N register file: two asynchronous reads, one synchronous write, synchronous clear.
module affine_rf_p #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREG = 8,
  localparam int unsigned R   = $clog2(NREG)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         we_i,
  input  logic [R-1:0] waddr_i,
  input  logic [N-1:0] wdata_i,
  input  logic [R-1:0] raddr_a_i,
  output logic [N-1:0] rdata_a_o,
  input  logic [R-1:0] raddr_b_i,
  output logic [N-1:0] rdata_b_o
);

  logic [N-1:0] regs_q [NREG];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/affine_core_p.sv
// Single-issue affine sequencer: writable program store, register file, run/halt control
// and a valid/ready input port with registered output strobe.
module affine_core_p
  import affine_p_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned NREG    = 8,
  localparam int unsigned A      = $clog2(DEPTH),
  localparam int unsigned R      = $clog2(NREG),
  localparam int unsigned W_INST = inst_w(N, R)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              prog_we_i,
  input  logic [A-1:0]      prog_addr_i,
  input  logic [W_INST-1:0] prog_data_i,
  input  logic              start_i,
  input  logic [N-1:0]      ext_data_i,
  input  logic              ext_valid_i,
  output logic              ext_ready_o,
  output logic [N-1:0]      ext_data_o,
  output logic              ext_strobe_o,
  output logic              busy_o,
  output logic              halted_o
);

  localparam int unsigned RdLsb  = rd_lsb();
  localparam int unsigned RsLsb  = rs_lsb(R);
  localparam int unsigned ImmLsb = imm_lsb(R);

  logic [W_INST-1:0] mem_q [DEPTH];

  tStateP       state_q, state_d;
  logic [A-1:0] pc_q, pc_d;
  logic [N-1:0] out_q, out_d;
  logic         strobe_q, strobe_d;

  logic [W_INST-1:0] inst;
  tOpP               op_w;
  logic [R-1:0]      rd_a, rs_a;
  logic [N-1:0]      imm, rd_data, rs_data, dec_w;
  logic              rf_we;
  logic [N-1:0]      rf_wdata;
  logic              run;

  assign inst    = mem_q[pc_q];
  assign op_w    = tOpP'(inst[OpW-1:0]);
  assign rd_a    = inst[RdLsb +: R];
  assign rs_a    = inst[RsLsb +: R];
  assign imm     = inst[ImmLsb +: N];
  assign dec_w   = rd_data - N'(1);
  assign run     = (state_q == StRun);

  affine_rf_p #(
    .N   (N),
    .NREG(NREG)
  ) u_rf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (rf_we),
    .waddr_i  (rd_a),
    .wdata_i  (rf_wdata),
    .raddr_a_i(rd_a),
    .rdata_a_o(rd_data),
    .raddr_b_i(rs_a),
    .rdata_b_o(rs_data)
  );

  // Store is writable only while not running; reset also blocks a pending write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && prog_we_i && (state_q != StRun)) begin
      mem_q[prog_addr_i] <= prog_data_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    out_d    = out_q;
    strobe_d = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = '0;
    unique case (state_q)
      StIdle, StHalted: begin
        if (start_i) begin
          state_d = StRun;
          pc_d    = '0;
        end
      end
      StRun: begin
        pc_d = pc_q + A'(1);
        case (op_w)
          OpLdi: begin rf_we = 1'b1; rf_wdata = imm; end
          OpAdd: begin rf_we = 1'b1; rf_wdata = rd_data + rs_data; end
          OpSub: begin rf_we = 1'b1; rf_wdata = rd_data - rs_data; end
          OpMul: begin rf_we = 1'b1; rf_wdata = rd_data * rs_data; end
          OpMac: begin rf_we = 1'b1; rf_wdata = rd_data + rs_data * imm; end
          OpIn: begin
            // Hold pc and registers until the producer offers data.
            if (ext_valid_i) begin
              rf_we    = 1'b1;
              rf_wdata = ext_data_i;
            end else begin
              pc_d = pc_q;
            end
          end
          OpOut: begin
            out_d    = rs_data;
            strobe_d = 1'b1;
          end
          OpBnz: begin
            if (rs_data != '0) pc_d = imm[A-1:0];
          end
          OpDjnz: begin
            rf_we    = 1'b1;
            rf_wdata = dec_w;
            if (dec_w != '0) pc_d = imm[A-1:0];
          end
          OpHalt: begin
            state_d = StHalted;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      out_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
    end
  end

  assign ext_ready_o  = run && (op_w == OpIn);
  assign ext_data_o   = out_q;
  assign ext_strobe_o = strobe_q;
  assign busy_o       = run;
  assign halted_o     = (state_q == StHalted);

endmodule

// File: tb/tb_affine_core_p.sv
// Directed-vector bench for affine_core_p with hand-computed expected outputs.
module tb_affine_core_p;
  import affine_p_pkg::*;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NREG  = 8;
  localparam int unsigned A     = 4;
  localparam int unsigned R     = 3;
  localparam int unsigned WI    = 18;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          prog_we_i = 1'b0;
  logic [A-1:0]  prog_addr_i = '0;
  logic [WI-1:0] prog_data_i = '0;
  logic          start_i = 1'b0;
  logic [N-1:0]  ext_data_i = '0;
  logic          ext_valid_i = 1'b0;
  logic          ext_ready_o;
  logic [N-1:0]  ext_data_o;
  logic          ext_strobe_o;
  logic          busy_o;
  logic          halted_o;

  affine_core_p #(
    .N    (N),
    .DEPTH(DEPTH),
    .NREG (NREG)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .prog_we_i   (prog_we_i),
    .prog_addr_i (prog_addr_i),
    .prog_data_i (prog_data_i),
    .start_i     (start_i),
    .ext_data_i  (ext_data_i),
    .ext_valid_i (ext_valid_i),
    .ext_ready_o (ext_ready_o),
    .ext_data_o  (ext_data_o),
    .ext_strobe_o(ext_strobe_o),
    .busy_o      (busy_o),
    .halted_o    (halted_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  int strobe_cnt = 0;
  int mac_cnt = 0;
  logic [N-1:0] last_out = '0;

  // Monitor at the falling edge; stimulus samples these one time unit later.
  always @(negedge clk_i) begin
    if (ext_strobe_o) begin
      strobe_cnt = strobe_cnt + 1;
      last_out   = ext_data_o;
    end
    if (busy_o && (dut.op_w == OpMac)) mac_cnt = mac_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  function automatic logic [WI-1:0] enc(input tOpP op, input int rd, input int rs, input int imm);
    logic [R-1:0] d, s;
    logic [N-1:0] i;
    d = R'(rd);
    s = R'(rs);
    i = N'(imm);
    return {i, s, d, op};
  endfunction

  task automatic load(input int addr, input logic [WI-1:0] w);
    prog_we_i   = 1'b1;
    prog_addr_i = A'(addr);
    prog_data_i = w;
    tick();
    prog_we_i   = 1'b0;
  endtask

  task automatic start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int k = 0;
    while (!halted_o && k < 300) begin
      tick();
      k++;
    end
    check(tag, 32'(halted_o), 32'd1);
  endtask

  task automatic wait_strobes(input int target);
    int k = 0;
    while (strobe_cnt < target && k < 300) begin
      tick();
      k++;
    end
    check("strobe_budget", strobe_cnt, target);
  endtask

  initial begin
    int s0, m0;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s0, m0, k;

    // Reset state
    tick();
    tick();
    check("rst_busy", 32'(busy_o), 0);
    check("rst_halted", 32'(halted_o), 0);
    check("rst_ready", 32'(ext_ready_o), 0);
    check("rst_strobe", 32'(ext_strobe_o), 0);
    check("rst_data", 32'(ext_data_o), 0);
    rst_i = 1'b0;

    // Basic add: 5 + 7 = 12
    load(0, enc(OpLdi, 1, 0, 5));
    load(1, enc(OpLdi, 2, 0, 7));
    load(2, enc(OpAdd, 1, 2, 0));
    load(3, enc(OpOut, 0, 1, 0));
    load(4, enc(OpHalt, 0, 0, 0));
    s0 = strobe_cnt;
    start();
    check("busy_after_start", 32'(busy_o), 1);
    wait_halt("halt_add");
    check("add_out", 32'(last_out), 12);
    check("add_strobes", strobe_cnt - s0, 1);
    check("add_busy_low", 32'(busy_o), 0);

    // Wrap: 250 + 10 = 4 mod 256
    load(0, enc(OpLdi, 1, 0, 250));
    load(1, enc(OpLdi, 2, 0, 10));
    start();
    wait_halt("halt_wrap");
    check("wrap_add", 32'(last_out), 4);

    // 3 - 5 = 254 mod 256
    load(0, enc(OpLdi, 1, 0, 3));
    load(1, enc(OpLdi, 2, 0, 5));
    load(2, enc(OpSub, 1, 2, 0));
    start();
    wait_halt("halt_sub");
    check("wrap_sub", 32'(last_out), 254);

    // MAC/DJNZ loop: 4 iterations of r1 += 3*2 = 24
    load(0, enc(OpLdi, 3, 0, 4));
    load(1, enc(OpLdi, 1, 0, 0));
    load(2, enc(OpLdi, 2, 0, 3));
    load(3, enc(OpMac, 1, 2, 2));
    load(4, enc(OpDjnz, 3, 0, 3));
    load(5, enc(OpOut, 0, 1, 0));
    load(6, enc(OpHalt, 0, 0, 0));
    m0 = mac_cnt;
    start();
    wait_halt("halt_loop");
    check("loop_out", 32'(last_out), 24);
    check("loop_macs", mac_cnt - m0, 4);

    // IN stall; a store write attempted in RUN must not land
    load(0, enc(OpIn, 1, 0, 0));
    load(1, enc(OpOut, 0, 1, 0));
    load(2, enc(OpHalt, 0, 0, 0));
    s0 = strobe_cnt;
    start();
    for (int i = 0; i < 5; i++) begin
      check("stall_ready", 32'(ext_ready_o), 1);
      check("stall_pc", 32'(dut.pc_q), 0);
      prog_we_i   = (i == 2);
      prog_addr_i = A'(1);
      prog_data_i = enc(OpHalt, 0, 0, 0);
      tick();
    end
    prog_we_i   = 1'b0;
    ext_data_i  = 8'h3C;
    ext_valid_i = 1'b1;
    tick();
    ext_valid_i = 1'b0;
    check("in_ready_drop", 32'(ext_ready_o), 0);
    wait_halt("halt_in");
    check("in_out", 32'(last_out), 32'h3C);
    check("run_write_ignored", strobe_cnt - s0, 1);

    // Restart from HALTED keeps r1 = 0x3C: doubled gives 0x78
    load(0, enc(OpAdd, 1, 1, 0));
    load(1, enc(OpOut, 0, 1, 0));
    load(2, enc(OpHalt, 0, 0, 0));
    start();
    wait_halt("halt_restart");
    check("restart_retained", 32'(last_out), 32'h78);

    // No HALT: pc wraps 15 -> 0; second pass sees r6 = 1
    load(0, enc(OpAdd, 5, 6, 0));
    load(1, enc(OpOut, 0, 5, 0));
    for (int a = 2; a < 15; a++) load(a, enc(OpNop, 0, 0, 0));
    load(15, enc(OpLdi, 6, 0, 1));
    s0 = strobe_cnt;
    start();
    wait_strobes(s0 + 2);
    check("pc_wrap_out", 32'(last_out), 1);
    check("pc_wrap_busy", 32'(busy_o), 1);

    // Reset during a stall clears state, outputs and registers
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    load(0, enc(OpLdi, 1, 0, 9));
    load(1, enc(OpOut, 0, 1, 0));
    load(2, enc(OpIn, 2, 0, 0));
    load(3, enc(OpHalt, 0, 0, 0));
    start();
    k = 0;
    while (!ext_ready_o && k < 50) begin
      tick();
      k++;
    end
    check("pre_rst_ready", 32'(ext_ready_o), 1);
    check("pre_rst_data", 32'(ext_data_o), 9);
    tick();
    rst_i = 1'b1;
    tick();
    check("midrst_busy", 32'(busy_o), 0);
    check("midrst_halted", 32'(halted_o), 0);
    check("midrst_ready", 32'(ext_ready_o), 0);
    check("midrst_strobe", 32'(ext_strobe_o), 0);
    check("midrst_data", 32'(ext_data_o), 0);
    for (int i = 0; i < int'(NREG); i++) begin
      check("midrst_reg", 32'(dut.u_rf.regs_q[i]), 0);
    end
    rst_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
